iot_event_tx: RTL
=================

Name: iot_event_tx

Overview:
Event-source side of the active-IoT-devices monitor link. It watches N device presence lines and detects join (rising) and leave (falling) transitions. It queues these as per-device pending events and issues them one per clock onto the monitor's on_off/change interface. It also keeps a shadow active-device count, which must always equal the monitor's counter once all pending events have drained.

Parameters:
N_DEV, 8, number of device presence lines (2..255)
CNT_W, 8, width of shadow_count; must match the monitor counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
dev_active  input  N_DEV  per-device presence level, synchronous to clk
en  input  1  issue enable; 0 holds off issuing, detection continues
on_off  output  1  registered; 1 = monitor counts this cycle
change  output  1  registered; 1 = increment (join), 0 = decrement (leave)
dev_id  output  $clog2(N_DEV)  registered; device index of the issued event
shadow_count  output  CNT_W  registered; number of devices whose join has been issued and whose leave has not
pending_any  output  1  combinational OR of all pending flags

Behaviour:
- Reset (rst=0, async):
  - on_off=0, change=1, dev_id=0, shadow_count=0.
  - prev_active=0, all devices IDLE, round-robin pointer=0.
- Edge detection, every cycle: rise[i]=dev_active[i]&~prev_active[i]; fall[i]=~dev_active[i]&prev_active[i]; prev_active<=dev_active.
- Per-device pending state {IDLE, JOIN, LEAVE}. Each cycle the grant is applied first, then the edge:
  - A granted device goes to IDLE.
  - rise: IDLE->JOIN; LEAVE->IDLE (cancel, no event).
  - fall: IDLE->LEAVE; JOIN->IDLE (cancel, no event).
  - A grant and an opposite edge in the same cycle yields the new pending event, e.g. JOIN granted + fall -> LEAVE.
- Arbitration:
  - Round-robin over devices not IDLE, only when en=1.
  - Search starts at the pointer; the pointer moves to granted index+1, wrapping at N_DEV.
  - At most one grant per cycle.
- Output register, on the clock edge after a grant:
  - on_off=1, change=(state==JOIN), dev_id=granted index.
  - shadow_count is +1 for a join and -1 for a leave.
- No grant (en=0 or nothing pending): on_off=0; change and dev_id hold their last values; shadow_count holds.
- Latency: a lone rise on device i sampled at edge k gives on_off=1, change=1, dev_id=i in the cycle after edge k+1 (2 cycles).
- Back-pressure: none from the monitor. en=0 only defers events; pending flags persist and none are lost.
- Devices present at reset release: prev_active=0, so each asserted line generates a join.
- Invariants:
  - shadow_count never exceeds N_DEV and never underflows. A leave is only issued after that device's join was issued.
  - After drain, shadow_count equals popcount(dev_active).
- Mid-operation reset: all pending events are discarded; behaviour restarts as after power-on.

Decomposition:
- Shared package iot_pkg:
  - dev_state_t enum {IDLE=2'd0, JOIN=2'd1, LEAVE=2'd2}
  - CNT_W_DEFAULT=8, N_DEV_DEFAULT=8
- Sub-module rr_arbiter:
  - parameter N; inputs req[N], en; outputs gnt_valid, gnt_idx; internal pointer register.
  - Same clk/rst convention.
- Top level holds edge detection, the per-device state array, the output register and shadow_count.

Test Plan:
- Reset with dev_active=8'h00, then release -> on_off=0, shadow_count=0 indefinitely; hold rst=0 mid-run with events pending -> outputs and shadow_count return to 0 immediately, asynchronously.
- dev_active 8'h00->8'h04 at edge k -> on_off=1, change=1, dev_id=2 in the cycle after edge k+1 only; shadow_count=1; then 8'h04->8'h00 -> one on_off pulse with change=0, dev_id=2; shadow_count=0.
- dev_active 8'h00->8'hFF in one cycle -> 8 consecutive on_off pulses, dev_id 0,1,...,7, all change=1; shadow_count steps to 8; pending_any falls after the last grant.
- Device 3 pulses high for 1 cycle while en=0 -> both edges cancel: no event on re-enable, shadow_count unchanged.
- en=0 with devices 1 and 5 joining, then en=1 -> grants dev_id 1 then 5. With the pointer then at 6, simultaneous leaves on 1 and 5 -> order is 1, then 5 after wrap. shadow_count goes 2 then 0.
- Device 0 JOIN granted in the same cycle its line falls -> join pulse, then leave pulse on the next cycle; shadow_count 1 then 0.
- Random dev_active stimulus with an integrated 8-bit up/down reference counter driven by on_off/change -> counter equals shadow_count every cycle, and equals popcount(dev_active) once pending_any=0.

Source files
------------

// File: rtl/iot_pkg.sv
// Shared types and defaults for the IoT event-source link.
package iot_pkg;

  localparam int unsigned N_DEV_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // Per-device pending-event state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    JOIN  = 2'd1,
    LEAVE = 2'd2
  } dev_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer,
// pointer advances to granted index + 1 (wrapping at N).
module rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // First requester at or after the pointer, modulo N
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned sum;
      int unsigned cand;
      // ptr_q < N and off < N, so a single conditional subtract wraps
      sum  = 32'(ptr_q) + off;
      cand = (sum >= N) ? (sum - N) : sum;
      if (en && !gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // Next pointer: one past the granted index, wrapping to 0
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/iot_event_tx.sv
// Event source for the active-device monitor: detects join/leave edges on
// device presence lines, queues them per device, and issues one per clock
// as an on_off/change pulse while tracking a shadow active-device count.
module iot_event_tx
  import iot_pkg::*;
#(
  parameter int unsigned N_DEV = N_DEV_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DEV-1:0]         dev_active,
  input  logic                     en,
  output logic                     on_off,
  output logic                     change,
  output logic [$clog2(N_DEV)-1:0] dev_id,
  output logic [CNT_W-1:0]         shadow_count,
  output logic                     pending_any
);

  localparam int unsigned ID_W = $clog2(N_DEV);

  logic [N_DEV-1:0] prev_q;
  logic [N_DEV-1:0] rise, fall;
  logic [N_DEV-1:0] req;

  dev_state_t state_q [N_DEV];
  dev_state_t state_d [N_DEV];

  logic            gnt_valid;
  logic [ID_W-1:0] gnt_idx;

  logic            on_off_q;
  logic            change_q;
  logic [ID_W-1:0] dev_id_q;
  logic [CNT_W-1:0] count_q;

  assign rise = dev_active & ~prev_q;
  assign fall = ~dev_active & prev_q;

  // Previous presence levels for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= '0;
    else      prev_q <= dev_active;
  end

  // A device requests service whenever it holds a pending event
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      req[i] = (state_q[i] != IDLE);
    end
  end

  assign pending_any = |req;

  rr_arbiter #(
    .N(N_DEV)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (en),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // Pending-state update: clear the granted device first, then apply edges,
  // so a grant plus an opposite edge leaves the new event pending
  always_comb begin
    state_d = state_q;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (gnt_valid && (gnt_idx == ID_W'(i))) begin
        state_d[i] = IDLE;
      end
      if (rise[i]) begin
        case (state_d[i])
          IDLE:    state_d[i] = JOIN;
          LEAVE:   state_d[i] = IDLE;
          default: state_d[i] = state_d[i];
        endcase
      end else if (fall[i]) begin
        case (state_d[i])
          IDLE:    state_d[i] = LEAVE;
          JOIN:    state_d[i] = IDLE;
          default: state_d[i] = state_d[i];
        endcase
      end
    end
  end

  // Per-device pending-state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_DEV; i++) begin
        state_q[i] <= IDLE;
      end
    end else begin
      state_q <= state_d;
    end
  end

  // Issue register and shadow count; change/dev_id hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      on_off_q <= 1'b0;
      change_q <= 1'b1;
      dev_id_q <= '0;
      count_q  <= '0;
    end else if (gnt_valid) begin
      on_off_q <= 1'b1;
      change_q <= (state_q[gnt_idx] == JOIN);
      dev_id_q <= gnt_idx;
      if (state_q[gnt_idx] == JOIN) count_q <= count_q + CNT_W'(1);
      else                          count_q <= count_q - CNT_W'(1);
    end else begin
      on_off_q <= 1'b0;
    end
  end

  assign on_off       = on_off_q;
  assign change       = change_q;
  assign dev_id       = dev_id_q;
  assign shadow_count = count_q;

endmodule
